// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and digit-select type for the BCD display scanner.
package seg7_pkg;

    // Active-high gfedcba patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_sel_e;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Capture bus from binary_to_bcd into the display scanner.
interface bcd_seg_scan_if;
    logic       load;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       valid;

    modport master (output load, output tens, output ones, output valid);
    modport slave  (input load, input tens, input ones, input valid);
endinterface

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; codes 10..15 decode to blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pat
);

    // Table lookup with a blank default for non-decimal codes.
    always_comb begin
        pat = SEG_BLANK;
        case (bcd)
            4'd0: pat = SEG_DIGIT[0];
            4'd1: pat = SEG_DIGIT[1];
            4'd2: pat = SEG_DIGIT[2];
            4'd3: pat = SEG_DIGIT[3];
            4'd4: pat = SEG_DIGIT[4];
            4'd5: pat = SEG_DIGIT[5];
            4'd6: pat = SEG_DIGIT[6];
            4'd7: pat = SEG_DIGIT[7];
            4'd8: pat = SEG_DIGIT[8];
            4'd9: pat = SEG_DIGIT[9];
            default: pat = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver: captures a BCD pair, scans digits,
// blinks a dash while the captured value is invalid.
module bcd_seg_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter bit          LZ_BLANK       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_seg_scan_if.slave        bus,
    input  logic                 en,
    output logic [6:0]           seg,
    output logic [1:0]           an,
    output logic                 frame_done
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // XOR masks that double as the "everything off" output levels.
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_OFF  = {2{AN_ACTIVE_LOW}};

    logic [3:0]       tens_q;
    logic [3:0]       ones_q;
    logic             valid_q;
    logic [DIV_W-1:0] div_cnt;
    dig_sel_e         digit_sel;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;

    logic             div_last;
    logic             frame_tick;
    logic             lz_hide;
    logic [3:0]       cur_digit;
    logic [6:0]       digit_pat;
    logic [6:0]       pat;
    logic [1:0]       an_sel;

    assign cur_digit = (digit_sel == DIG_TENS) ? tens_q : ones_q;

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .pat (digit_pat)
    );

    // Slot/frame timing and the pattern for the digit currently selected.
    always_comb begin
        div_last   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
        frame_tick = en && div_last && (digit_sel == DIG_TENS);
        lz_hide    = LZ_BLANK && valid_q && (digit_sel == DIG_TENS) && (tens_q == 4'd0);
        an_sel     = (digit_sel == DIG_TENS) ? 2'b10 : 2'b01;
        pat        = digit_pat;
        if (!valid_q) begin
            pat = blink_on ? SEG_DASH : SEG_BLANK;
        end else if (lz_hide) begin
            pat    = SEG_BLANK;
            an_sel = 2'b00;
        end
    end

    // Capture on load; otherwise advance the blink timer once per frame while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            valid_q   <= 1'b1;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (bus.load) begin
            tens_q    <= bus.tens;
            ones_q    <= bus.ones;
            valid_q   <= bus.valid;
            blink_cnt <= '0;
            blink_on  <= ~bus.valid;  // dash visible immediately on an invalid capture
        end else if (!valid_q && frame_tick) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Refresh divider and digit select; both freeze while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_sel <= DIG_ONES;
        end else if (en) begin
            if (div_last) begin
                div_cnt   <= '0;
                digit_sel <= (digit_sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Registered, polarity-adjusted display outputs and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else if (en) begin
            seg        <= pat ^ SEG_OFF;
            an         <= an_sel ^ AN_OFF;
            frame_done <= frame_tick;
        end else begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream consumer of binary_to_bcd. Captures the {tens, ones, valid} result on a load strobe and drives a 2-digit multiplexed 7-segment display. Digit 0 shows ones and digit 1 shows tens, each shown in its own time slot from a refresh divider. An invalid input shows a blinking dash pattern. Leading-zero blanking is optional.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period while invalid (>=1)
LZ_BLANK, 1, 1 = blank the tens digit when its captured value is 0 and valid
SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode)
AN_ACTIVE_LOW, 1, 1 = an outputs inverted

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture strobe for tens/ones/valid
tens  input  4  BCD tens digit from binary_to_bcd
ones  input  4  BCD ones digit from binary_to_bcd
valid  input  1  1 = tens/ones meaningful
en  input  1  display enable
seg  output  7  segments, seg[0]=a ... seg[6]=g
an  output  2  digit enables, an[0]=ones, an[1]=tens
frame_done  output  1  1-cycle pulse at end of each 2-slot frame

Behaviour:
- Reset (async assert, sync release) forces:
  - tens_q=0, ones_q=0, valid_q=1.
  - div_cnt=0, digit_sel=0, blink_cnt=0, blink_on=0.
  - seg all segments off, an all digits inactive, frame_done=0. Polarity follows the parameters.
- Capture: load=1 at an edge registers tens/ones/valid into tens_q/ones_q/valid_q. Capture happens regardless of en.
  - If the captured valid=1: blink_cnt=0, blink_on=0.
  - If the captured valid=0: blink_cnt=0, blink_on=1, so the dash appears at once.
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps. At the terminal count, digit_sel toggles.
  - The 1->0 toggle also raises frame_done for that edge only.
  - frame_done is registered; it is high in the cycle after the edge where digit_sel wraps 1->0.
- Blink: runs only while valid_q=0. On each frame_done, blink_cnt increments.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - If load arrives on the same edge as a frame boundary, load wins.
- Pattern selection (active-high gfedcba), computed for the current digit_sel:
  - valid_q=0: dash 0x40 if blink_on, else blank 0x00.
  - valid_q=1 and digit value 0..9: 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
  - valid_q=1 and digit value 10..15: blank 0x00. This is a defensive case only.
  - LZ_BLANK=1, valid_q=1, digit_sel=1 and tens_q=0: that digit's anode is inactive for the slot.
- Output registers: seg and an are registered. They reflect digit_sel and the captured values as of the previous edge, so latency is 1 cycle.
  - A load in a slot changes seg on the second edge after load.
  - Exactly one an bit is active per slot, unless blanked or disabled.
- en=0: div_cnt and digit_sel hold, and an goes all inactive on the next edge. seg is driven to blank. Scanning resumes from the held state when en returns to 1.
- Reset mid-frame: outputs are forced inactive immediately (asynchronously). After release, the first edge starts digit 0.
- Polarity: seg = pattern ^ {7{SEG_ACTIVE_LOW}}. an is the one-hot select, inverted when AN_ACTIVE_LOW.

Decomposition:
- Package seg7_pkg holds:
  - SEG_DIGIT[0:9] constants, SEG_DASH, SEG_BLANK.
  - A 2-value digit-select typedef (DIG_ONES, DIG_TENS).
- One natural combinational sub-module, bcd_to_seg7: 4-bit BCD in, 7-bit active-high pattern out, blank for 10..15. It is instanced once on the muxed digit.
- Divider, blink logic and output registers stay in bcd_seg_scan.

Test Plan:
Bench parameters: REFRESH_DIV=4, BLINK_FRAMES=2, LZ_BLANK=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0.
1. Reset behaviour: hold rst_n=0 mid-run -> seg=0x00, an=2'b00 without waiting for a clock edge. Release -> a=0x3F on an=2'b01 for 4 cycles, then an=2'b00 (tens blanked) for 4 cycles.
2. Valid load: load tens=4, ones=2, valid=1 -> alternating slots of 4 cycles. seg=0x5B with an=2'b01, then seg=0x66 with an=2'b10. frame_done pulses once every 8 cycles.
3. Leading-zero blanking: load tens=0, ones=7, valid=1 -> an=2'b01 with seg=0x07 in the ones slot, and an=2'b00 in the tens slot.
4. Invalid load: load valid=0 -> seg=0x40 on both digits for 2 frames (16 cycles), blank for 2 frames, then repeats. Reload with valid=1, tens=1, ones=5 -> normal display "15" (0x06 / 0x6D), no blink.
5. Enable: en=0 during the tens slot -> an=2'b00 the next cycle, div_cnt frozen. en=1 -> the remaining tens-slot cycles complete before ones.
6. Defensive codes: load ones=4'hC, tens=4'hA, valid=1 -> seg=0x00 in both slots, and an stays active (1-hot) because only tens==0 triggers leading-zero blanking.
